// File: rtl/psk_tx_scheduler_pkg.sv
// Shared types and constants for the PSK transmit scheduler.
// Also carries the default parameter values used by the tx/rx timing blocks.
package psk_tx_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic MODE_BPSK = 1'b1;
   localparam logic MODE_QPSK = 1'b0;

   localparam int DEF_DIV_WIDTH    = 8;
   localparam int DEF_LEN_WIDTH    = 12;
   localparam int DEF_GUARD_CYCLES = 4;

endpackage

// File: rtl/psk_rate_divider.sv
// Loadable sample-rate divider; strobe is registered and high when the
// count equals the latched period-minus-one.
module psk_rate_divider
   import psk_tx_scheduler_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div_in,
   input  logic                 clear,
   input  logic                 run,
   output logic                 strobe
);

   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] cnt_inc;
   logic [DIV_WIDTH-1:0] div_eff;

   assign cnt_inc = cnt + ONE;
   assign div_eff = load ? div_in : div_q;

   // strobe mirrors (cnt == div_q) one step ahead, keeping the output registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         cnt    <= '0;
         strobe <= 1'b0;
      end else begin
         if (load) div_q <= div_in;
         if (clear) begin
            cnt    <= '0;
            strobe <= (div_eff == '0);
         end else if (run) begin
            if (strobe) begin
               cnt    <= '0;
               strobe <= (div_q == '0);
            end else begin
               cnt    <= cnt_inc;
               strobe <= (cnt_inc == div_q);
            end
         end else begin
            cnt    <= '0;
            strobe <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/psk_tx_scheduler.sv
// Round-robin BPSK/QPSK frame scheduler with guard interval on mode change.
// Drives the sample strobe and mode flag for the modulator stage.
module psk_tx_scheduler
   import psk_tx_scheduler_pkg::*;
#(
   parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
   parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] sample_div,
   input  logic                 bpsk_req,
   input  logic [LEN_WIDTH-1:0] bpsk_len,
   input  logic                 qpsk_req,
   input  logic [LEN_WIDTH-1:0] qpsk_len,
   output logic                 bpsk_grant,
   output logic                 qpsk_grant,
   output logic                 clk_enable,
   output logic                 is_bpsk,
   output logic                 frame_active,
   output logic                 frame_done
);

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [GW-1:0] G_ONE = GW'(1);
   localparam logic [LEN_WIDTH:0] S_ONE = (LEN_WIDTH + 1)'(1);

   state_t state, state_next;

   logic                 last_mode;
   logic                 rr_bpsk;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH:0]   scnt;
   logic [LEN_WIDTH:0]   scnt_inc;
   logic [LEN_WIDTH:0]   len_target;
   logic [GW-1:0]        gcnt;
   logic                 gnt_b;
   logic                 gnt_q;
   logic                 grant;
   logic                 last_strobe;
   logic                 div_clear;
   logic                 div_run;

   assign scnt_inc   = scnt + S_ONE;
   assign len_target = (len_q == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                     : {1'b0, len_q};
   assign last_strobe = clk_enable && (scnt_inc == len_target);

   always_comb begin
      gnt_b      = 1'b0;
      gnt_q      = 1'b0;
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            gnt_b = bpsk_req && (!qpsk_req || rr_bpsk);
            gnt_q = qpsk_req && (!bpsk_req || !rr_bpsk);
            if (gnt_b || gnt_q)
               state_next = (gnt_b != last_mode) ? ST_GUARD : ST_RUN;
         end
         ST_GUARD: begin
            if (gcnt == GUARD_LAST) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (last_strobe) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign grant     = gnt_b || gnt_q;
   assign div_run   = (state_next == ST_RUN);
   assign div_clear = div_run && (state != ST_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         bpsk_grant   <= 1'b0;
         qpsk_grant   <= 1'b0;
         is_bpsk      <= MODE_BPSK;
         last_mode    <= MODE_BPSK;
         rr_bpsk      <= 1'b1;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         len_q        <= '0;
         scnt         <= '0;
         gcnt         <= '0;
      end else begin
         state        <= state_next;
         bpsk_grant   <= gnt_b;
         qpsk_grant   <= gnt_q;
         frame_active <= (state_next != ST_IDLE);
         frame_done   <= (state == ST_RUN) && last_strobe;
         if (grant) begin
            is_bpsk <= gnt_b;
            rr_bpsk <= gnt_q;
            len_q   <= gnt_b ? bpsk_len : qpsk_len;
            scnt    <= '0;
            gcnt    <= '0;
            if (state_next == ST_GUARD) last_mode <= gnt_b;
         end
         if (state == ST_GUARD) gcnt <= gcnt + G_ONE;
         if (state == ST_RUN && clk_enable) scnt <= scnt_inc;
      end
   end

   psk_rate_divider #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .load  (grant),
      .div_in(sample_div),
      .clear (div_clear),
      .run   (div_run),
      .strobe(clk_enable)
   );

endmodule

// File: tb/tb_psk_tx_scheduler.sv
// Scoreboard bench for psk_tx_scheduler: a frame-level model predicts every
// grant, strobe and done pulse; a monitor pops and compares as they appear.
module tb_psk_tx_scheduler;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int GC = 4;

   localparam int K_GB   = 0;
   localparam int K_GQ   = 1;
   localparam int K_STB  = 2;
   localparam int K_DONE = 3;

   typedef struct {
      int kind;
      int cyc;
      bit b;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] sample_div = '0;
   logic          bpsk_req = 1'b0;
   logic [LW-1:0] bpsk_len = '0;
   logic          qpsk_req = 1'b0;
   logic [LW-1:0] qpsk_len = '0;
   logic          bpsk_grant;
   logic          qpsk_grant;
   logic          clk_enable;
   logic          is_bpsk;
   logic          frame_active;
   logic          frame_done;

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   ev_t exq[$];

   bit  m_last_bpsk = 1'b1;
   bit  m_rr_bpsk = 1'b1;

   psk_tx_scheduler #(
      .DIV_WIDTH   (DW),
      .LEN_WIDTH   (LW),
      .GUARD_CYCLES(GC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_div  (sample_div),
      .bpsk_req    (bpsk_req),
      .bpsk_len    (bpsk_len),
      .qpsk_req    (qpsk_req),
      .qpsk_len    (qpsk_len),
      .bpsk_grant  (bpsk_grant),
      .qpsk_grant  (qpsk_grant),
      .clk_enable  (clk_enable),
      .is_bpsk     (is_bpsk),
      .frame_active(frame_active),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: grant cycle, optional guard, evenly spaced strobes.
   task automatic model_frame(input bit b, input int g, input int div,
                              input int len, output int done);
      int gd;
      int n;
      int s;
      gd = (b != m_last_bpsk) ? GC : 0;
      n  = (len == 0) ? (1 << LW) : len;
      s  = 0;
      exq.push_back('{b ? K_GB : K_GQ, g, b});
      m_last_bpsk = b;
      m_rr_bpsk   = !b;
      for (int k = 0; k < n; k++) begin
         s = g + gd + div + k * (div + 1);
         exq.push_back('{K_STB, s, b});
      end
      done = s + 1;
      exq.push_back('{K_DONE, done, b});
   endtask

   task automatic mon(input int kind);
      ev_t e;
      bit  ok;
      total++;
      if (exq.size() == 0) begin
         bad++;
         $display("FAIL unexpected_pulse: got kind=%0d at cyc %0d, want none",
                  kind, cyc);
      end else begin
         e  = exq.pop_front();
         ok = (e.kind == kind) && (e.cyc == cyc);
         if (kind == K_STB) ok = ok && (is_bpsk == e.b) && frame_active;
         if (kind == K_GB || kind == K_GQ) ok = ok && frame_active;
         if (kind == K_DONE) ok = ok && !frame_active;
         if (!ok) begin
            bad++;
            $display("FAIL pulse: got kind=%0d cyc=%0d bpsk=%0b act=%0b, want kind=%0d cyc=%0d bpsk=%0b",
                     kind, cyc, is_bpsk, frame_active, e.kind, e.cyc, e.b);
         end
      end
   endtask

   always @(negedge clk) begin
      if (bpsk_grant) mon(K_GB);
      if (qpsk_grant) mon(K_GQ);
      if (clk_enable) mon(K_STB);
      if (frame_done) mon(K_DONE);
   end

   // mode: 0 BPSK only, 1 QPSK only, 2 both
   task automatic run_iter(input int mode, input int div, input int bl,
                           input int ql, input bit mutate);
      int  d;
      bit  fb;
      @(negedge clk);
      sample_div = DW'(div);
      bpsk_len   = LW'(bl);
      qpsk_len   = LW'(ql);
      bpsk_req   = (mode != 1);
      qpsk_req   = (mode != 0);
      if (mode == 2) begin
         fb = m_rr_bpsk;
         model_frame(fb, cyc + 1, div, fb ? bl : ql, d);
         model_frame(!fb, d + 1, div, fb ? ql : bl, d);
      end else begin
         model_frame(mode == 0, cyc + 1, div, (mode == 0) ? bl : ql, d);
      end
      while (cyc < d + 1) begin
         @(negedge clk);
         if (bpsk_grant) bpsk_req = 1'b0;
         if (qpsk_grant) qpsk_req = 1'b0;
         if (mutate && (bpsk_grant || qpsk_grant)) begin
            sample_div = DW'($urandom_range(0, 7));
            bpsk_len   = LW'($urandom);
            qpsk_len   = LW'($urandom);
         end
      end
      check("req_granted", int'(bpsk_req || qpsk_req), 0);
      bpsk_req = 1'b0;
      qpsk_req = 1'b0;
   endtask

   // Frame of 5 strobes at div 1, reset after the second strobe.
   task automatic reset_frame(input bit b);
      int g;
      int gd;
      int s2;
      @(negedge clk);
      sample_div = DW'(1);
      bpsk_len   = LW'(5);
      qpsk_len   = LW'(5);
      bpsk_req   = b;
      qpsk_req   = !b;
      g  = cyc + 1;
      gd = (b != m_last_bpsk) ? GC : 0;
      exq.push_back('{b ? K_GB : K_GQ, g, b});
      exq.push_back('{K_STB, g + gd + 1, b});
      exq.push_back('{K_STB, g + gd + 3, b});
      s2 = g + gd + 3;
      while (cyc < s2 + 1) begin
         @(negedge clk);
         if (bpsk_grant) bpsk_req = 1'b0;
         if (qpsk_grant) qpsk_req = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("rst_clk_enable", int'(clk_enable), 0);
      check("rst_frame_active", int'(frame_active), 0);
      check("rst_is_bpsk", int'(is_bpsk), 1);
      check("rst_grants", int'(bpsk_grant || qpsk_grant), 0);
      @(negedge clk);
      rst = 1'b0;
      m_last_bpsk = 1'b1;
      m_rr_bpsk   = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_no_more_pulses", exq.size(), 0);
      run_iter(2, 0, 2, 2, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, want finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_frame_active", int'(frame_active), 0);
      check("reset_is_bpsk", int'(is_bpsk), 1);
      check("reset_clk_enable", int'(clk_enable), 0);
      check("reset_done", int'(frame_done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_iter(0, 2, 3, 0, 1'b0);
      run_iter(1, 0, 0, 2, 1'b0);
      run_iter(0, 0, 1, 0, 1'b0);
      repeat (3) run_iter(2, 1, 2, 3, 1'b0);
      run_iter(0, 0, 0, 5, 1'b0);
      run_iter(0, 3, 6, 0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         int md;
         md = $urandom_range(0, 2);
         run_iter(md, $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 15),
                  (md != 2) && ($urandom_range(0, 1) == 1));
      end

      reset_frame(1'b1);
      reset_frame(1'b0);

      repeat (4) @(negedge clk);
      check("queue_drained", exq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
